// File: rtl/pb_pkg.sv
// pb_pkg: shared state encoding, default timing constants and counter sizing
// helper for the multi-channel pushbutton processor.
// Optional feature macro used by the design: PB_AUTO_REPEAT_EN.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } pb_state_e;

  localparam int DEF_N_CH        = 2;
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_LONG_MS     = 2000;
  localparam int DEF_REPEAT_MS   = 250;

  // Bits needed to represent every value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pushbutton_channel.sv
// pushbutton_channel: one button path -- 2-FF synchroniser, stable-time
// debouncer and short/long press classifier. With PB_AUTO_REPEAT_EN defined,
// a held long press re-fires press_long_o every REPEAT_MS cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | button released (debounced), waiting for a press
// PRESSED | press in progress, hold time still below the long threshold
// LONG    | long threshold reached, waiting for release
module pushbutton_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS
`ifdef PB_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
`endif
) (
  input  logic clk_1khz,
  input  logic rst_ni,
  input  logic pushbutton_i,
  output logic press_short_o,
  output logic press_long_o,
  output logic held_o
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_MS);
  localparam int HOLD_W = cnt_width(LONG_MS);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

`ifdef PB_AUTO_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_MS);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  logic [1:0]        sync_q;
  logic              sync_lvl;
  logic              deb_q;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              short_arm;
  pb_state_e         state;

  assign sync_lvl = sync_q[1];

  // Two-stage synchroniser for the asynchronous raw button level.
  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], pushbutton_i};
  end

  // Debounce: deb_q follows sync only after DEBOUNCE_MS consecutive mismatched cycles.
  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_lvl != deb_q) begin
      if (deb_cnt == DEB_LAST) begin
        deb_q   <= ~deb_q;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Press classifier with registered outputs. The FSM only returns to IDLE
  // once deb_q is low, so a high deb_q seen in IDLE is always a fresh rise.
  // The short pulse is staged through short_arm so it lands one cycle after
  // the FSM has observed the debounced release.
  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      short_arm     <= 1'b0;
      press_short_o <= 1'b0;
      press_long_o  <= 1'b0;
      held_o        <= 1'b0;
`ifdef PB_AUTO_REPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      press_long_o  <= 1'b0;
      short_arm     <= 1'b0;
      press_short_o <= short_arm;
      case (state)
        IDLE: begin
          if (deb_q) begin
            state    <= PRESSED;
            hold_cnt <= '0;
            held_o   <= 1'b1;
          end
        end
        PRESSED: begin
          if (hold_cnt == HOLD_LAST) begin
            // Threshold wins over a release landing on the same cycle.
            press_long_o <= 1'b1;
            if (deb_q) begin
              state <= LONG;
`ifdef PB_AUTO_REPEAT_EN
              rep_cnt <= '0;
`endif
            end else begin
              state  <= IDLE;
              held_o <= 1'b0;
            end
          end else if (!deb_q) begin
            state     <= IDLE;
            held_o    <= 1'b0;
            short_arm <= 1'b1;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (!deb_q) begin
            state  <= IDLE;
            held_o <= 1'b0;
          end
`ifdef PB_AUTO_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            press_long_o <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          held_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_pushbutton_processor.sv
// multi_pushbutton_processor: N_CH independent debounced pushbutton channels
// clocked by the 1 kHz tick (1 cycle = 1 ms). Optional feature macro:
// PB_AUTO_REPEAT_EN enables periodic press_long_o repeats while held.
module multi_pushbutton_processor
  import pb_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic            clk_1khz,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] pushbutton_i,
  output logic [N_CH-1:0] press_short_o,
  output logic [N_CH-1:0] press_long_o,
  output logic [N_CH-1:0] held_o
);

  // Refuse to build with a parameter set the timing rules cannot honour.
  if (N_CH < 1 || N_CH > 8 || DEBOUNCE_MS < 2 || LONG_MS <= DEBOUNCE_MS || REPEAT_MS < 1) begin : g_param_check
    $error("multi_pushbutton_processor: illegal parameter set");
  end

  // One fully independent channel per button.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pushbutton_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
`ifdef PB_AUTO_REPEAT_EN
      ,
      .REPEAT_MS   (REPEAT_MS)
`endif
    ) u_ch (
      .clk_1khz      (clk_1khz),
      .rst_ni        (rst_ni),
      .pushbutton_i  (pushbutton_i[i]),
      .press_short_o (press_short_o[i]),
      .press_long_o  (press_long_o[i]),
      .held_o        (held_o[i])
    );
  end

endmodule

// File: tb/tb_multi_pushbutton_processor.sv
// Bench for multi_pushbutton_processor: directed vector table, hand-written
// bounce/reset/repeat sequences, and a random run checked against a run-length
// reference model of the debounce and press-classification rules.
module tb_multi_pushbutton_processor;

  localparam int N_CH = 2;
  localparam int DEB  = 20;
  localparam int LONG = 2000;
  localparam int REP  = 250;
  localparam int MAXN = 6000;
  localparam int BIG  = 1 << 30;
`ifdef PB_AUTO_REPEAT_EN
  localparam int RPT_N    = 3;
  localparam int RPT_LAST = 2522;
`else
  localparam int RPT_N    = 1;
  localparam int RPT_LAST = 2022;
`endif

  logic            clk_1khz = 1'b0;
  logic            rst_ni   = 1'b0;
  logic [N_CH-1:0] pushbutton_i = '0;
  logic [N_CH-1:0] press_short_o, press_long_o, held_o;

  multi_pushbutton_processor #(
    .N_CH(N_CH), .DEBOUNCE_MS(DEB), .LONG_MS(LONG), .REPEAT_MS(REP)
  ) dut (
    .clk_1khz      (clk_1khz),
    .rst_ni        (rst_ni),
    .pushbutton_i  (pushbutton_i),
    .press_short_o (press_short_o),
    .press_long_o  (press_long_o),
    .held_o        (held_o)
  );

  always #5 clk_1khz = ~clk_1khz;

  typedef struct { int ns; int nl; int ts; int tl; int tr; int tf; } chan_exp_t;
  typedef struct { string name; int len0; int len1; int win; chan_exp_t e0; chan_exp_t e1; } vec_t;

  int total = 0;
  int bad   = 0;

  bit pat [N_CH][MAXN];
  bit exp_s [N_CH][MAXN];
  bit exp_l [N_CH][MAXN];
  bit exp_h [N_CH][MAXN];

  int n_short [N_CH];
  int n_long  [N_CH];
  int t_short [N_CH];
  int t_long  [N_CH];
  int t_last  [N_CH];
  int t_rise  [N_CH];
  int t_fall  [N_CH];
  int both_hi;

  vec_t vq[$];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic chan_exp_t ce(input int ns, input int nl, input int ts, input int tl, input int tr, input int tf);
    chan_exp_t r;
    r.ns = ns; r.nl = nl; r.ts = ts; r.tl = tl; r.tr = tr; r.tf = tf;
    return r;
  endfunction

  task automatic add_vec(input string name, input int len0, input int len1, input int win, input chan_exp_t a, input chan_exp_t b);
    vec_t v;
    v.name = name; v.len0 = len0; v.len1 = len1; v.win = win; v.e0 = a; v.e1 = b;
    vq.push_back(v);
  endtask

  task automatic clear_pat();
    for (int c = 0; c < N_CH; c++)
      for (int n = 0; n < MAXN; n++) pat[c][n] = 1'b0;
  endtask

  // Drive pat for len cycles (index n sampled by edge n) and gather per-channel event stats.
  task automatic run_pattern(input int len);
    bit prev [N_CH];
    for (int c = 0; c < N_CH; c++) begin
      n_short[c] = 0; n_long[c] = 0; t_short[c] = -1; t_long[c] = -1;
      t_last[c] = -1; t_rise[c] = -1; t_fall[c] = -1; prev[c] = held_o[c];
    end
    both_hi = 0;
    for (int n = 0; n < len; n++) begin
      for (int c = 0; c < N_CH; c++) pushbutton_i[c] = pat[c][n];
      @(posedge clk_1khz); #1;
      for (int c = 0; c < N_CH; c++) begin
        if (press_short_o[c]) begin n_short[c]++; if (t_short[c] < 0) t_short[c] = n; end
        if (press_long_o[c]) begin n_long[c]++; if (t_long[c] < 0) t_long[c] = n; t_last[c] = n; end
        if (held_o[c] && t_rise[c] < 0) t_rise[c] = n;
        if (!held_o[c] && prev[c] && t_fall[c] < 0) t_fall[c] = n;
        if (press_short_o[c] && press_long_o[c]) both_hi++;
        prev[c] = held_o[c];
      end
    end
  endtask

  task automatic check_chan(input string name, input int c, input chan_exp_t e);
    check({name, "/n_short"}, n_short[c], e.ns);
    check({name, "/n_long"},  n_long[c],  e.nl);
    check({name, "/t_short"}, t_short[c], e.ts);
    check({name, "/t_long"},  t_long[c],  e.tl);
    check({name, "/t_rise"},  t_rise[c],  e.tr);
    check({name, "/t_fall"},  t_fall[c],  e.tf);
  endtask

  task automatic mark(input int ch, input int t, input int kind, input int nlen);
    if (t >= 0 && t < nlen) begin
      if (kind == 0) exp_s[ch][t] = 1'b1;
      else           exp_l[ch][t] = 1'b1;
    end
  endtask

  // Reference model: debounced edges come from maximal raw runs of the
  // opposite level lasting at least DEB cycles; press events follow from the
  // rise/fall edge times with plain arithmetic.
  task automatic build_model(input int ch, input int nlen);
    int edges[$];
    int deb, s, e2, e, f, lt;
    for (int n = 0; n < nlen; n++) begin
      exp_s[ch][n] = 1'b0; exp_l[ch][n] = 1'b0; exp_h[ch][n] = 1'b0;
    end
    deb = 0; s = 0;
    while (s < nlen) begin
      e2 = s;
      while (e2 < nlen && pat[ch][e2] == pat[ch][s]) e2++;
      if (int'(pat[ch][s]) != deb && (e2 - s) >= DEB) begin
        edges.push_back(s + DEB + 1);
        deb = 1 - deb;
      end
      s = e2;
    end
    for (int i = 0; i < edges.size(); i += 2) begin
      e  = edges[i];
      f  = (i + 1 < edges.size()) ? edges[i+1] : BIG;
      lt = e + 1 + LONG;
      for (int t = e + 1; t <= f && t < nlen; t++) exp_h[ch][t] = 1'b1;
      if (f + 1 < lt) mark(ch, f + 2, 0, nlen);
      else begin
        mark(ch, lt, 1, nlen);
`ifdef PB_AUTO_REPEAT_EN
        for (int t = lt + REP; t <= f && t < nlen; t += REP) mark(ch, t, 1, nlen);
`endif
      end
    end
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_1khz);
    #1 rst_ni = 1'b1;
  endtask

  chan_exp_t none_e;

  initial begin
    none_e = ce(0, 0, -1, -1, -1, -1);
    add_vec("glitch15_ch1",  0,  15,   80, none_e, none_e);
    add_vec("len19_ch0",     19, 0,    80, none_e, none_e);
    add_vec("len20_ch0",     20, 0,   100, ce(1, 0, 43, -1, 22, 42), none_e);
    add_vec("short100_long2100", 100, 2100, 2200, ce(1, 0, 123, -1, 22, 122), ce(0, 1, -1, 2022, 22, 2122));
    add_vec("len1999_ch0", 1999, 0,  2100, ce(1, 0, 2022, -1, 22, 2021), none_e);
    add_vec("len2000_tie", 2000, 0,  2100, ce(0, 1, -1, 2022, 22, 2022), none_e);
    add_vec("long2100_ch0", 2100, 0, 2200, ce(0, 1, -1, 2022, 22, 2122), none_e);
    add_vec("both30",        30, 30,  100, ce(1, 0, 53, -1, 22, 52), ce(1, 0, 53, -1, 22, 52));

    // Reset state.
    repeat (3) @(posedge clk_1khz);
    #1;
    check("reset/held",  int'(held_o), 0);
    check("reset/short", int'(press_short_o), 0);
    check("reset/long",  int'(press_long_o), 0);
    rst_ni = 1'b1;

    // Directed table.
    foreach (vq[k]) begin
      clear_pat();
      for (int n = 0; n < vq[k].len0; n++) pat[0][n] = 1'b1;
      for (int n = 0; n < vq[k].len1; n++) pat[1][n] = 1'b1;
      run_pattern(vq[k].win);
      check_chan({vq[k].name, "/ch0"}, 0, vq[k].e0);
      check_chan({vq[k].name, "/ch1"}, 1, vq[k].e1);
      check({vq[k].name, "/both_hi"}, both_hi, 0);
    end

    // Bouncy press: 1H 2L 2H 1L then high 32 cycles, release at 38.
    clear_pat();
    pat[0][0] = 1'b1; pat[0][3] = 1'b1; pat[0][4] = 1'b1;
    for (int n = 6; n < 38; n++) pat[0][n] = 1'b1;
    run_pattern(150);
    check_chan("bounce/ch0", 0, ce(1, 0, 61, -1, 28, 60));
    check_chan("bounce/ch1", 1, none_e);

    // Reset in the middle of a hold, button kept pressed through reset.
    clear_pat();
    for (int n = 0; n < 1000; n++) pat[0][n] = 1'b1;
    run_pattern(1000);
    check("midreset/pre_held0", int'(held_o[0]), 1);
    rst_ni = 1'b0;
    #1;
    check("midreset/async_out", int'({press_short_o, press_long_o, held_o}), 0);
    repeat (3) @(posedge clk_1khz);
    #1;
    check("midreset/in_reset_out", int'({press_short_o, press_long_o, held_o}), 0);
    rst_ni = 1'b1;
    clear_pat();
    for (int n = 0; n < 2100; n++) pat[0][n] = 1'b1;
    run_pattern(2200);
    check_chan("midreset/ch0", 0, ce(0, 1, -1, 2022, 22, 2122));

    // Long hold of 2600 cycles: repeats only when the feature is built in.
    clear_pat();
    for (int n = 0; n < 2600; n++) pat[0][n] = 1'b1;
    run_pattern(2800);
    check("hold2600/n_long", n_long[0], RPT_N);
    check("hold2600/t_long_first", t_long[0], 2022);
    check("hold2600/t_long_last", t_last[0], RPT_LAST);
    check("hold2600/n_short", n_short[0], 0);
    check("hold2600/t_fall", t_fall[0], 2622);

    // Random run against the reference model.
    pushbutton_i = '0;
    pulse_reset();
    for (int c = 0; c < N_CH; c++) begin
      int n, lv, sel, rl;
      n = 0; lv = 0;
      while (n < MAXN) begin
        sel = int'($urandom_range(0, 9));
        if (sel <= 3)      rl = int'($urandom_range(1, DEB - 1));
        else if (sel <= 7) rl = int'($urandom_range(DEB, 150));
        else if (sel == 8) rl = int'($urandom_range(LONG - 10, LONG + 10));
        else               rl = int'($urandom_range(200, 600));
        for (int k = 0; k < rl && n < MAXN; k++) begin
          pat[c][n] = lv[0];
          n++;
        end
        lv = 1 - lv;
      end
      build_model(c, MAXN);
    end
    for (int n = 0; n < MAXN; n++) begin
      logic [5:0] got, want;
      for (int c = 0; c < N_CH; c++) pushbutton_i[c] = pat[c][n];
      @(posedge clk_1khz); #1;
      got  = {press_short_o, press_long_o, held_o};
      want = {exp_s[1][n], exp_s[0][n], exp_l[1][n], exp_l[0][n], exp_h[1][n], exp_h[0][n]};
      check($sformatf("random/n=%0d {short,long,held}", n), int'(got), int'(want));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_pushbutton_processor.md
Name: multi_pushbutton_processor

Overview:
Parametrised N-channel successor to the single-button processor. Every channel has its own 2-FF synchroniser, stable-time debouncer and press classifier. Each channel emits one-cycle short-press and long-press event pulses plus a held level. It sits between the board pushbuttons and the scoreboard counter logic, clocked by the 1 kHz system tick, so 1 cycle = 1 ms.

Parameters:
N_CH, 2, number of independent button channels (1..8)
DEBOUNCE_MS, 20, consecutive stable cycles required before the debounced level changes (>=2)
LONG_MS, 2000, cycles a press must be held before it is classified as long (> DEBOUNCE_MS)
REPEAT_MS, 250, auto-repeat period in cycles (used only with PB_AUTO_REPEAT_EN)

Ports:
clk_1khz  input  1  1 kHz system clock; all logic on the rising edge
rst_ni  input  1  asynchronous, active-low reset
pushbutton_i  input  N_CH  raw, asynchronous, bouncing button levels; 1 = pressed
press_short_o  output  N_CH  1-cycle pulse per channel on release of a short press
press_long_o  output  N_CH  1-cycle pulse per channel when the long threshold is reached
held_o  output  N_CH  level; 1 while the channel is in PRESSED or LONG

Behaviour:
- Reset: rst_ni low clears, asynchronously, all synchroniser flops, debounce counters, hold counters and repeat counters. All channel FSMs go to IDLE. All outputs are 0 during reset and on the first cycle after release.
- Synchroniser: 2 flops per channel, reset value 0. The raw input reaches the synchronised level (sync) after 2 cycles.
- Debouncer, per channel:
  - deb is the debounced level; it resets to 0.
  - The counter increments each cycle while sync != deb.
  - The counter clears to 0 on any cycle where sync == deb.
  - When the counter reaches DEBOUNCE_MS-1 while still mismatched, deb toggles and the counter clears.
  - Any bounce shorter than DEBOUNCE_MS cycles is invisible.
- Classifier FSM, per channel; states are IDLE, PRESSED, LONG:
  - IDLE: on a rising edge of deb, go to PRESSED and clear hold_cnt.
  - PRESSED: hold_cnt increments every cycle.
  - PRESSED, deb falls: press_short_o pulses for 1 cycle (the cycle after the fall); go to IDLE.
  - PRESSED, hold_cnt == LONG_MS-1: press_long_o pulses for 1 cycle; go to LONG.
  - PRESSED, deb falls on the same cycle that hold_cnt hits LONG_MS-1: this counts as long. The long pulse fires, no short pulse fires, and the FSM goes to IDLE.
  - LONG: on a fall of deb, go to IDLE with no pulse.
  - hold_cnt saturates; it never wraps.
- Latency: from the raw stable edge to a state change is 2 sync cycles + DEBOUNCE_MS cycles. The short-press pulse fires 1 cycle after the debounced fall.
- Width rules:
  - Counter widths are derived with $clog2(param+1).
  - hold_cnt is sized for LONG_MS.
  - Widths are not truncated at the parameter bounds.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses in the same cycle.
- press_short_o and press_long_o are never both high on the same channel in the same cycle.

Optional Feature:
Macro PB_AUTO_REPEAT_EN.
- Defined:
  - Entering LONG clears rep_cnt.
  - While in LONG, press_long_o pulses again each time rep_cnt reaches REPEAT_MS-1; rep_cnt then clears.
  - Repeat pulses stop on release, with no trailing pulse.
- Undefined: rep_cnt and its logic are absent, and there is exactly one press_long_o pulse per hold.

Decomposition:
- Shared package pb_pkg holds:
  - the FSM state encoding (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2)
  - the default timing constants
  - a width helper for counter sizing
- One sub-module, pushbutton_channel: synchroniser, debouncer and FSM for a single channel. The top instantiates N_CH copies in a generate loop.

Test Plan:
Configuration for all scenarios: N_CH=2, DEBOUNCE_MS=20, LONG_MS=2000, REPEAT_MS=250.
1. ch0 bounces (1 ms high, 2 ms low, 2 ms high, 1 ms low, 2 ms high), then holds 30 ms and releases -> exactly one press_short_o[0] pulse, 23 cycles after the release (2 sync + 20 debounce + 1); held_o[0] high for about 30 ms; ch1 stays silent.
2. ch1 glitch high for 15 ms -> no pulses and held_o[1] stays 0.
3. ch0 held 2100 ms -> one press_long_o[0] pulse, 2022 cycles after the press edge; no press_short_o on release; held_o[0] falls 22 cycles after release.
4. ch0 short press of 100 ms concurrent with ch1 long press of 2100 ms -> one short pulse on ch0 and one long pulse on ch1; no cross-talk between channels.
5. rst_ni asserted 1000 ms into a ch0 hold, released with the button still pressed -> all outputs 0; the hold restarts, with the long pulse 2022 cycles after reset release.
6. With PB_AUTO_REPEAT_EN defined, ch0 held 2600 ms -> press_long_o[0] pulses at 2022, 2272 and 2522 cycles after the press edge, then nothing after release.
